fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  permits starting a new frame; sampled only in IDLE.
REQ-005 empty  input  1  FIFO empty flag; high = no byte available.
REQ-006 read  output  1  FIFO pop strobe; high for exactly one cycle per byte.
REQ-007 datain  input  8  FIFO dataout; valid exactly one cycle after the read cycle.
REQ-008 txd  output  1  serial line, idle high, LSB first.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 States SHALL be IDLE, REQ, LOAD, START, DATA, (PARITY), STOP.
REQ-011 IDLE: enable=1 and empty=0 -> REQ next cycle; otherwise stay IDLE, txd=1, read=0.
REQ-012 REQ: read=1 for this single cycle; unconditional -> LOAD.
REQ-013 LOAD: capture datain into an 8-bit shift register at the edge ending LOAD; -> START; the byte is never re-sampled later, because the FIFO zeroes its output one cycle afterwards.
REQ-014 START: txd=0 for CLKS_PER_BIT cycles; txd falls at the edge ending LOAD.
REQ-015 DATA: 8 bits, bit 0 first, each held CLKS_PER_BIT cycles; 3-bit bit counter wraps 7->0 on exit.
REQ-016 STOP: txd=1 for CLKS_PER_BIT cycles; -> IDLE.
REQ-017 Baud counter SHALL be at least ceil(log2(CLKS_PER_BIT)) bits, count 0..CLKS_PER_BIT-1, clear on every state change, never overflow.
REQ-018 Back-to-back bytes: one IDLE cycle between STOP end and next REQ; frame-to-frame spacing = 3 + 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-019 enable falling mid-frame SHALL NOT abort the frame; the block stops at the next IDLE.
REQ-020 empty SHALL be ignored outside IDLE; read SHALL never assert while empty=1 was sampled in IDLE.
REQ-021 txd, read and busy SHALL be registered or decoded directly from the state register, with no combinational path from inputs.

Reset
REQ-022 resetn=0 SHALL immediately force state=IDLE, txd=1, read=0, busy=0, counters=0, shift register=0x00.
REQ-023 Reset mid-frame SHALL discard the in-flight byte; it is not re-read from the FIFO.
REQ-024 After resetn rises, the first REQ SHALL occur no earlier than the second rising edge.

Configuration
REQ-025 FIFO_UART_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP; txd = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
REQ-026 FIFO_UART_TX_PARITY_EN undefined: no PARITY state and no parity logic; frame is 8N1.

Verification (CLKS_PER_BIT=4)
REQ-027 Single byte: FIFO holds 0xA5, enable=1 -> read high exactly 1 cycle; txd = 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles; busy high 42 cycles.
REQ-028 Back-to-back: FIFO holds 0x00 then 0xFF -> two read pulses 43 cycles apart; second frame = 0, eight 1s, 1; FIFO ends empty and read stays low.
REQ-029 Empty/disabled: empty=1 or enable=0 for 100 cycles -> read=0, txd=1, busy=0 throughout.
REQ-030 Reset mid-frame: resetn=0 during DATA bit 3 -> same-cycle txd=1, busy=0; after release with FIFO holding 0x3C, the next frame carries 0x3C and not the aborted byte.
REQ-031 Parity (macro defined): 0xA5 -> parity bit 0; 0x07 -> parity bit 1; frame length 11 bits.
REQ-032 enable drop: enable=0 in START of a 0x81 frame -> full frame sent, then block idles with FIFO non-empty.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO-side and serial-side signals of the FIFO-fed UART transmitter.
// master drives the FIFO flags/data and enable; slave is the transmitter.
interface fifo_uart_tx_if;
  logic       enable;
  logic       empty;
  logic       read;
  logic [7:0] datain;
  logic       txd;
  logic       busy;

  modport master (output enable, empty, datain, input read, txd, busy);
  modport slave  (input enable, empty, datain, output read, txd, busy);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a FIFO and sends them 8N1, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic           clock,
  input  logic           resetn,
  fifo_uart_tx_if.slave  bus
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             txd_q;
  logic             read_q;
  logic             busy_q;
  logic             armed_q;
  logic             baud_last;

  assign baud_last = (baud_q == CNT_LAST);

  // armed_q holds off the first request until the second edge after reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= 8'h00;
      txd_q   <= 1'b1;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      read_q  <= 1'b0;
      baud_q  <= '0;
      case (state_q)
        S_IDLE: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
          if (armed_q && bus.enable && !bus.empty) begin
            state_q <= S_REQ;
            read_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_REQ: state_q <= S_LOAD;
        S_LOAD: begin
          shift_q <= bus.datain;
          txd_q   <= 1'b0;
          state_q <= S_START;
        end
        S_START: begin
          if (baud_last) begin
            txd_q   <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        // Rotating rather than shifting keeps the full byte for parity.
        S_DATA: begin
          if (baud_last) begin
            bit_q   <= bit_q + 3'd1;
            shift_q <= {shift_q[0], shift_q[7:1]};
            if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              txd_q   <= ^shift_q;
              state_q <= S_PARITY;
`else
              txd_q   <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              txd_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_last) begin
            txd_q   <= 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_last) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
        default: begin
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.txd  = txd_q;
  assign bus.read = read_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a small FIFO model.
module tb_fifo_uart_tx;

  localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FB        = 11;
  localparam int BUSY_EXP  = 46;
  localparam int GAP_EXP   = 47;
  localparam logic [10:0] F_A5 = 11'h54A;
  localparam logic [10:0] F_00 = 11'h400;
  localparam logic [10:0] F_FF = 11'h5FE;
  localparam logic [10:0] F_07 = 11'h60E;
  localparam logic [10:0] F_81 = 11'h502;
  localparam logic [10:0] F_3C = 11'h478;
`else
  localparam int FB        = 10;
  localparam int BUSY_EXP  = 42;
  localparam int GAP_EXP   = 43;
  localparam logic [10:0] F_A5 = 11'h34A;
  localparam logic [10:0] F_00 = 11'h200;
  localparam logic [10:0] F_FF = 11'h3FE;
  localparam logic [10:0] F_07 = 11'h20E;
  localparam logic [10:0] F_81 = 11'h302;
  localparam logic [10:0] F_3C = 11'h278;
`endif

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
    int          busy;
    int          gap;
  } vec_t;

  logic clock;
  logic resetn;
  fifo_uart_tx_if bus ();

  fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // FIFO model: output valid one cycle after the pop, zero otherwise.
  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_empty_err = 0;
  assign bus.empty = (wr_ptr == rd_ptr);

  always @(posedge clock) begin
    if (bus.read === 1'b1) begin
      if (wr_ptr != rd_ptr) begin
        bus.datain <= mem[rd_ptr % 16];
        rd_ptr     <= rd_ptr + 1;
      end else begin
        bus.datain   <= 8'h00;
        rd_empty_err <= rd_empty_err + 1;
      end
    end else begin
      bus.datain <= 8'h00;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for a pop, then checks every serial bit, the pop width and busy span.
  task automatic run_frame(input string tag, input logic [10:0] exp_frame,
                           input int exp_busy, input bit drop_en, output int req_cyc);
    int waited;
    int busy_cnt;
    int reads;
    bit bad;
    logic got;
    waited = 0;
    req_cyc = -1;
    forever begin
      @(negedge clock);
      if (bus.read === 1'b1) break;
      waited++;
      if (waited > 200) break;
    end
    check({tag, "_req_seen"}, 32'(bus.read), 32'd1);
    if (bus.read !== 1'b1) return;
    req_cyc = cyc;
    busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
    reads = 0;
    @(negedge clock);
    check({tag, "_read_width"}, 32'(bus.read), 32'd0);
    if (bus.busy === 1'b1) busy_cnt++;
    for (int b = 0; b < FB; b++) begin
      bad = 1'b0;
      got = exp_frame[b];
      for (int c = 0; c < C; c++) begin
        @(negedge clock);
        if (drop_en && b == 0 && c == 0) bus.enable = 1'b0;
        if (bus.txd !== exp_frame[b]) begin
          bad = 1'b1;
          got = bus.txd;
        end
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.read !== 1'b0) reads++;
      end
      check($sformatf("%s_bit%0d", tag, b), 32'(got), 32'(exp_frame[b]));
    end
    @(negedge clock);
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, "_extra_reads"}, 32'(reads), 32'd0);
  endtask

  task automatic idle_window(input string tag, input int n);
    int rd_hi;
    int tx_lo;
    int bz_hi;
    rd_hi = 0; tx_lo = 0; bz_hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (bus.read !== 1'b0) rd_hi++;
      if (bus.txd !== 1'b1) tx_lo++;
      if (bus.busy !== 1'b0) bz_hi++;
    end
    check({tag, "_read_cycles"}, 32'(rd_hi), 32'd0);
    check({tag, "_txd_low_cycles"}, 32'(tx_lo), 32'd0);
    check({tag, "_busy_cycles"}, 32'(bz_hi), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int req_c;
    int prev_req;
    int rel_cyc;

    vecs[0] = '{data: 8'hA5, frame: F_A5, busy: BUSY_EXP, gap: 0};
    vecs[1] = '{data: 8'h00, frame: F_00, busy: BUSY_EXP, gap: GAP_EXP};
    vecs[2] = '{data: 8'hFF, frame: F_FF, busy: BUSY_EXP, gap: GAP_EXP};
    vecs[3] = '{data: 8'h07, frame: F_07, busy: BUSY_EXP, gap: GAP_EXP};

    resetn = 1'b0;
    bus.enable = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_txd", 32'(bus.txd), 32'd1);
    check("rst_read", 32'(bus.read), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Table: all bytes queued up front so frames run back-to-back.
    foreach (vecs[i]) push(vecs[i].data);
    bus.enable = 1'b1;
    prev_req = 0;
    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("v%0d", i), vecs[i].frame, vecs[i].busy, 1'b0, req_c);
      if (i > 0) check($sformatf("v%0d_gap", i), 32'(req_c - prev_req), 32'(vecs[i].gap));
      prev_req = req_c;
    end
    check("table_fifo_empty", 32'(bus.empty), 32'd1);

    idle_window("empty_idle", 100);

    push(8'h81);
    push(8'h5A);
    bus.enable = 1'b0;
    idle_window("disabled_idle", 100);

    // Enable dropped during START: frame completes, then block stays idle.
    bus.enable = 1'b1;
    run_frame("drop", F_81, BUSY_EXP, 1'b1, req_c);
    check("drop_enable_low", 32'(bus.enable), 32'd0);
    idle_window("drop_idle", 30);
    check("drop_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);

    // Reset in the middle of data bit 3 of the 0x5A frame.
    bus.enable = 1'b1;
    req_c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.read === 1'b1) break;
    end
    check("rstmid_req_seen", 32'(bus.read), 32'd1);
    repeat (17) @(negedge clock);
    check("rstmid_bit2_txd", 32'(bus.txd), 32'd0);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("rstmid_txd", 32'(bus.txd), 32'd1);
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_read", 32'(bus.read), 32'd0);
    push(8'h3C);
    repeat (3) @(negedge clock);
    check("rstmid_hold_busy", 32'(bus.busy), 32'd0);
    resetn = 1'b1;
    rel_cyc = cyc;
    @(negedge clock);
    check("post_rst_first_edge_read", 32'(bus.read), 32'd0);
    run_frame("after_rst", F_3C, BUSY_EXP, 1'b0, req_c);
    check("post_rst_req_edge", 32'(req_c - rel_cyc), 32'd2);
    check("final_fifo_empty", 32'(bus.empty), 32'd1);
    idle_window("final_idle", 20);
    check("read_while_empty", 32'(rd_empty_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
